pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Sequences the program counter for instruction fetch.
- Holds the 32-bit PC and steps it by STEP on every accepted fetch.
- Issues fetch requests to instruction memory over a valid/ready handshake.
- Handles run/stall control and taken-branch redirects; sits between core control and instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, PC increment per accepted fetch (bytes).
- ADDR_W, 32, PC/address width.

Ports:
- clk  in  1  single clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = fetching enabled.
- stall  in  1  1 = freeze issue of new fetches.
- br_taken  in  1  one-cycle redirect strobe.
- br_target  in  ADDR_W  redirect address.
- fetch_ready  in  1  instruction memory accepts the request.
- fetch_valid  out  1  request pending; registered.
- fetch_addr  out  ADDR_W  request address; equals pc.
- pc  out  ADDR_W  current PC; registered.
- misalign_err  out  1  sticky; br_target[1:0] != 0 was seen.
- fetch_count  out  32  accepted fetches; counts only under PERF_CNT_EN.
- stall_cycles  out  32  cycles spent in STALL; counts only under PERF_CNT_EN.

Behaviour:
- States: IDLE, FETCH, STALL. fetch_valid = (state == FETCH), registered.
- Reset (rst_n=0, asynchronous, any time including mid-handshake):
  - state=IDLE, pc=RESET_PC, fetch_valid=0, misalign_err=0, counters=0.
  - An outstanding request is dropped with no PC step.
- Transitions evaluate at posedge; priority is br_taken > handshake > run/stall. "Exit" means: run=0 -> IDLE, else stall=1 -> STALL, else FETCH.
  - br_taken=1 (any state):
    - pc <= {br_target[ADDR_W-1:2], 2'b00}.
    - Pending request withdrawn with no step, even if fetch_ready=1 that cycle.
    - next state = exit rule.
    - br_target[1:0] != 0 sets misalign_err; it clears only on reset.
  - IDLE: run=1 -> FETCH, or STALL if stall=1. run=0 -> stay in IDLE.
  - FETCH, fetch_ready=1: pc <= pc + STEP, modulo 2^ADDR_W (32'hFFFF_FFFC -> 0); fetch_count++; next state = exit rule.
  - FETCH, fetch_ready=0: hold. fetch_valid and fetch_addr stay stable; run and stall are ignored until acceptance.
  - STALL: run=0 -> IDLE; else stall=0 -> FETCH; else stay and stall_cycles++.
- Latency:
  - run rising in IDLE -> fetch_valid=1 on the next cycle.
  - Back-to-back acceptances give one fetch per cycle, addresses +STEP apart.
  - Redirect -> first request at the target on the next cycle.
- fetch_count and stall_cycles wrap at 2^32.

Optional Feature:
- Macro: PC_SEQ_PERF_CNT_EN.
- Defined: fetch_count and stall_cycles count as described above.
- Undefined: no counter flops are built; both ports are tied to 32'd0. All other behaviour is identical.

Decomposition:
- Package pc_seq_pkg holds:
  - State encoding constants ST_IDLE=2'd0, ST_FETCH=2'd1, ST_STALL=2'd2.
  - Default RESET_PC and STEP constants.
  - Alignment mask constant 32'hFFFF_FFFC.
- Sub-module pc_step_reg:
  - Async active-low reset to RESET_PC.
  - Controls: load (target, alignment-masked), step (+STEP), hold otherwise.
  - load has priority over step.
- The FSM stays in pc_fetch_sequencer.

Test Plan:
- Reset, then run=1, fetch_ready=1 for 4 cycles -> fetch_addr sequence 0,4,8,12; pc=16; fetch_count=4.
- fetch_ready=0 for 3 cycles at pc=8 -> fetch_valid=1 and fetch_addr=8 stable; on ready, pc=12. Asserting stall during the wait has no effect until acceptance.
- br_taken with br_target=32'h0000_0102 while a request is pending -> pc=32'h100; no step; misalign_err=1 and stays 1.
- stall=1 for 5 cycles after acceptance -> STALL, fetch_valid=0, stall_cycles=4 (macro on) or 0 (macro off); resumes at the same pc.
- RESET_PC=32'hFFFF_FFF8, two acceptances -> addresses FFFF_FFF8, FFFF_FFFC; pc wraps to 0.
- rst_n asserted mid-FETCH with fetch_ready=0 -> fetch_valid=0 immediately (async), pc=RESET_PC; run=0 holds IDLE.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared constants and state encoding for the PC fetch sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned DEFAULT_STEP     = 4;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage

// File: rtl/pc_step_reg.sv
// Program counter register: aligned load, fixed step, or hold.
module pc_step_reg
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       STEP     = DEFAULT_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;

  // Only the two low address bits are cleared, whatever ADDR_W is.
  localparam logic [ADDR_W-1:0] LOW_BITS = ADDR_W'(~ALIGN_MASK);

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target_i & ~LOW_BITS;
    end else if (step_i) begin
      pc_d = pc_q + ADDR_W'(STEP);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Instruction-fetch PC sequencer: IDLE/FETCH/STALL FSM with branch redirect.
// Define PC_SEQ_PERF_CNT_EN to build the fetch and stall performance counters.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned       STEP     = DEFAULT_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              fetch_ready,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign_err,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_cycles
);

  state_e state_q, state_d;
  state_e exit_state;
  logic   fetch_valid_q, fetch_valid_d;
  logic   misalign_q, misalign_d;
  logic   accept;

  // A redirect withdraws the pending request even when memory is ready.
  assign accept = (state_q == ST_FETCH) && fetch_ready && !br_taken;

  always_comb begin
    exit_state = !run ? ST_IDLE : (stall ? ST_STALL : ST_FETCH);
  end

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    if (br_taken) begin
      state_d = exit_state;
    end else begin
      unique case (state_q)
        ST_FETCH: if (fetch_ready) state_d = exit_state;
        default:  state_d = exit_state;
      endcase
    end
    fetch_valid_d = (state_d == ST_FETCH);
    misalign_d    = misalign_q | (br_taken && (br_target[1:0] != 2'b00));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  pc_step_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC),
    .STEP    (STEP)
  ) u_pc (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (br_taken),
    .target_i(br_target),
    .step_i  (accept),
    .pc_o    (pc)
  );

`ifdef PC_SEQ_PERF_CNT_EN
  logic [31:0] fetch_count_q, stall_cycles_q;
  logic        stall_hold;

  assign stall_hold = (state_q == ST_STALL) && (state_d == ST_STALL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (accept)     fetch_count_q  <= fetch_count_q + 32'd1;
      if (stall_hold) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign stall_cycles = stall_cycles_q;
`else
  assign fetch_count  = 32'd0;
  assign stall_cycles = 32'd0;
`endif

  assign fetch_valid  = fetch_valid_q;
  assign fetch_addr   = pc;
  assign misalign_err = misalign_q;

endmodule
